// File: rtl/int_mul_unit.sv
// Iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU) publishing to the CDB.
// Optional `MUL_EARLY_OUT_EN skips the shift-add loop when an operand is zero.
module int_mul_unit #(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [31:0]      rs1_data,
   input  logic [31:0]      rs2_data,
   input  logic [TAG_W:0]   rd_token,
   input  logic [2:0]       funct3,
   output logic             ex_done,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic             cdb_valid,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [31:0]      cdb_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [5:0]       count_q, count_d;
   logic [63:0]      acc_q, acc_d;
   logic [63:0]      mcand_q, mcand_d;
   logic [31:0]      mplier_q, mplier_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             tokValid_q, tokValid_d;
   logic             signA_q, signA_d;
   logic             signB_q, signB_d;
   logic             exDone_q, exDone_d;
   logic [TAG_W-1:0] cdbTag_q, cdbTag_d;
   logic [31:0]      cdbData_q, cdbData_d;

   logic             signA, signB;
   logic [31:0]      magA, magB;
   logic             zeroOperand;
   logic [63:0]      fixProduct;

   // Only MULH treats rs2 as signed; MULH and MULHSU treat rs1 as signed.
   assign signA = rs1_data[31] & ((funct3 == 3'b001) | (funct3 == 3'b010));
   assign signB = rs2_data[31] & (funct3 == 3'b001);
   assign magA  = signA ? (~rs1_data + 32'd1) : rs1_data;
   assign magB  = signB ? (~rs2_data + 32'd1) : rs2_data;

`ifdef MUL_EARLY_OUT_EN
   assign zeroOperand = (rs1_data == 32'h0) | (rs2_data == 32'h0);
`else
   assign zeroOperand = 1'b0;
`endif

   assign fixProduct = (signA_q ^ signB_q) ? (~acc_q + 64'd1) : acc_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      funct3_d   = funct3_q;
      tag_d      = tag_q;
      tokValid_d = tokValid_q;
      signA_d    = signA_q;
      signB_d    = signB_q;
      exDone_d   = 1'b0;
      cdbTag_d   = cdbTag_q;
      cdbData_d  = cdbData_q;

      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               funct3_d   = funct3;
               tag_d      = rd_token[TAG_W-1:0];
               tokValid_d = rd_token[TAG_W];
               signA_d    = signA;
               signB_d    = signB;
               mcand_d    = {32'h0, magA};
               mplier_d   = magB;
               acc_d      = 64'h0;
               count_d    = 6'd0;
               exDone_d   = 1'b1;
               state_d    = zeroOperand ? FIX : CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            count_d  = count_q + 6'd1;
            if (count_q == 6'd31) begin
               count_d = 6'd0;
               state_d = FIX;
            end
         end
         FIX: begin
            // Non-multiply encodings (funct3[2] set) always publish zero.
            if (funct3_q[2]) begin
               cdbData_d = 32'h0;
            end else if (funct3_q[1:0] == 2'b00) begin
               cdbData_d = fixProduct[31:0];
            end else begin
               cdbData_d = fixProduct[63:32];
            end
            cdbTag_d = tag_q;
            state_d  = tokValid_q ? WB : IDLE;
         end
         WB: begin
            if (cdb_grant) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         count_q    <= 6'd0;
         acc_q      <= 64'h0;
         mcand_q    <= 64'h0;
         mplier_q   <= 32'h0;
         funct3_q   <= 3'b000;
         tag_q      <= '0;
         tokValid_q <= 1'b0;
         signA_q    <= 1'b0;
         signB_q    <= 1'b0;
         exDone_q   <= 1'b0;
         cdbTag_q   <= '0;
         cdbData_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         funct3_q   <= funct3_d;
         tag_q      <= tag_d;
         tokValid_q <= tokValid_d;
         signA_q    <= signA_d;
         signB_q    <= signB_d;
         exDone_q   <= exDone_d;
         cdbTag_q   <= cdbTag_d;
         cdbData_q  <= cdbData_d;
      end
   end

   assign ex_done   = exDone_q;
   assign cdb_req   = (state_q == WB);
   assign cdb_valid = (state_q == WB) & cdb_grant;
   assign cdb_tag   = cdbTag_q;
   assign cdb_data  = cdbData_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_int_mul_unit.sv
// Self-checking bench for int_mul_unit: directed scenarios plus randomized
// operations against an arithmetic reference model.
module tb_int_mul_unit;

   localparam int TAG_W = 6;
`ifdef MUL_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             issue_valid;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic [TAG_W:0]   rd_token;
   logic [2:0]       funct3;
   logic             ex_done;
   logic             cdb_req;
   logic             cdb_grant;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;
   logic             busy;

   int nCompared;
   int nMismatched;

   int_mul_unit #(.TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rd_token    (rd_token),
      .funct3      (funct3),
      .ex_done     (ex_done),
      .cdb_req     (cdb_req),
      .cdb_grant   (cdb_grant),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // RV32M reference computed with wide arithmetic.
   function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, ub, ps;
      longint unsigned ua2, ub2, pu;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'h0, b});
      ua2 = {32'h0, a};
      ub2 = {32'h0, b};
      case (f3)
         3'b000: begin pu = ua2 * ub2; return pu[31:0]; end
         3'b001: begin ps = sa * sb;   return ps[63:32]; end
         3'b010: begin ps = sa * ub;   return ps[63:32]; end
         3'b011: begin pu = ua2 * ub2; return pu[63:32]; end
         default: return 32'h0;
      endcase
   endfunction

   function automatic int expLatency(input logic [31:0] a, input logic [31:0] b);
      return (EARLY_OUT && (a == 32'h0 || b == 32'h0)) ? 2 : 34;
   endfunction

   // Issues one op at the next edge and observes it until the unit is idle.
   // grantDelay < 0 ties grant high throughout.
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tg, input logic tv, input int grantDelay,
                                input bit holdIssue,
                                output int exDoneCyc, output int exDoneCnt, output int reqCyc,
                                output logic [31:0] data, output logic [TAG_W-1:0] tagOut,
                                output int validCnt, output int stray, output int idleCyc,
                                output bit unstable, output bit timedOut);
      int reqAge;
      exDoneCyc = -1; exDoneCnt = 0; reqCyc = -1; data = 32'h0; tagOut = '0;
      validCnt = 0; stray = 0; idleCyc = -1; unstable = 1'b0; timedOut = 1'b1; reqAge = 0;
      issue_valid = 1'b1;
      rs1_data    = a;
      rs2_data    = b;
      funct3      = f3;
      rd_token    = {tv, tg};
      cdb_grant   = (grantDelay < 0);
      @(posedge clk); #1;
      if (!holdIssue) issue_valid = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (ex_done) begin
            exDoneCnt++;
            if (exDoneCyc < 0) exDoneCyc = cyc;
         end
         if (!busy) begin
            idleCyc  = cyc;
            timedOut = 1'b0;
            break;
         end
         if (cdb_req) begin
            if (reqCyc < 0) begin
               reqCyc = cyc;
               data   = cdb_data;
               tagOut = cdb_tag;
            end else if (cdb_data !== data || cdb_tag !== tagOut) begin
               unstable = 1'b1;
            end
            if (grantDelay >= 0) cdb_grant = (reqAge >= grantDelay);
            reqAge++;
         end else if (grantDelay >= 0) begin
            cdb_grant = 1'b0;
         end
         #1;
         if (cdb_valid) begin
            if (cdb_req) validCnt++;
            else stray++;
         end
         @(posedge clk); #1;
      end
      cdb_grant = 1'b0;
   endtask

   task automatic test_reset();
      issue_valid = 1'b1; rs1_data = 32'd9; rs2_data = 32'd9; funct3 = 3'b000;
      rd_token = 7'h41; cdb_grant = 1'b1;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      nCompared++;
      if ({ex_done, cdb_req, cdb_valid, busy} !== 4'b0000) begin
         nMismatched++;
         $display("FAIL reset_ctrl: got %b expected 0000", {ex_done, cdb_req, cdb_valid, busy});
      end
      nCompared++;
      if (cdb_tag !== '0 || cdb_data !== 32'h0) begin
         nMismatched++;
         $display("FAIL reset_data: got tag %h data %h expected 0/0", cdb_tag, cdb_data);
      end
      repeat (2) @(posedge clk);
      #1;
      nCompared++;
      if (busy !== 1'b0 || ex_done !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_hold: got busy %b ex_done %b expected 0/0", busy, ex_done);
      end
      issue_valid = 1'b0; cdb_grant = 1'b0;
      #3 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_mul();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      applyStimulus(3'b000, 32'd7, 32'd6, 6'h15, 1'b1, -1, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (edc !== 1 || edn !== 1) begin
         nMismatched++;
         $display("FAIL basic_ex_done: got cycle %0d count %0d expected 1/1", edc, edn);
      end
      nCompared++;
      if (rc !== 34) begin
         nMismatched++;
         $display("FAIL basic_req_cycle: got %0d expected 34", rc);
      end
      nCompared++;
      if (d !== 32'd42 || t !== 6'h15) begin
         nMismatched++;
         $display("FAIL basic_result: got data %0d tag %h expected 42/15", d, t);
      end
      nCompared++;
      if (vc !== 1 || st !== 0) begin
         nMismatched++;
         $display("FAIL basic_valid: got %0d in WB %0d outside expected 1/0", vc, st);
      end
      nCompared++;
      if (ic !== 35 || to) begin
         nMismatched++;
         $display("FAIL basic_idle: got cycle %0d timeout %0d expected 35/0", ic, to);
      end
   endtask

   task automatic test_high_words();
      logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] as  [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs  [3] = '{32'd3, 32'hFFFFFFFF, 32'd2};
      logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(f3s[i], as[i], bs[i], 6'(i + 8), 1'b1, 0, 1'b0,
                       edc, edn, rc, d, t, vc, st, ic, un, to);
         nCompared++;
         if (d !== exp[i] || rc !== 34 || t !== 6'(i + 8)) begin
            nMismatched++;
            $display("FAIL high_word_%0d: got data %h cycle %0d tag %h expected %h/34/%h",
                     i, d, rc, t, exp[i], 6'(i + 8));
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      issue_valid = 1'b1; rs1_data = 32'd100; rs2_data = 32'd200; funct3 = 3'b000;
      rd_token = {1'b1, 6'h2A};
      @(posedge clk); #1;
      issue_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 cdb_grant = 1'b1;
      rst = 1'b0;
      #1;
      nCompared++;
      if ({ex_done, cdb_req, cdb_valid, busy} !== 4'b0000 || cdb_tag !== '0 || cdb_data !== 32'h0) begin
         nMismatched++;
         $display("FAIL reset_mid_calc: got ctrl %b tag %h data %h expected all zero",
                  {ex_done, cdb_req, cdb_valid, busy}, cdb_tag, cdb_data);
      end
      @(posedge clk); #3 rst = 1'b1; cdb_grant = 1'b0;
      @(posedge clk); #1;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      nCompared++;
      if (ex_done !== 1'b1) begin
         nMismatched++;
         $display("FAIL reset_pulse_pre: got ex_done %b expected 1", ex_done);
      end
      rst = 1'b0;
      #1;
      nCompared++;
      if (ex_done !== 1'b0 || busy !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_pulse_lost: got ex_done %b busy %b expected 0/0", ex_done, busy);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      applyStimulus(3'b000, 32'd3, 32'd5, 6'h07, 1'b1, 0, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (d !== 32'd15 || rc !== 34 || t !== 6'h07 || vc !== 1) begin
         nMismatched++;
         $display("FAIL reset_recover: got data %0d cycle %0d tag %h valid %0d expected 15/34/07/1",
                  d, rc, t, vc);
      end
   endtask

   task automatic test_grant_stall();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      logic [31:0] got2; bit seen2, drained;
      applyStimulus(3'b000, 32'h12345, 32'h777, 6'h3C, 1'b1, 10, 1'b1,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (rc !== 34 || un || d !== 32'h12345 * 32'h777 || t !== 6'h3C) begin
         nMismatched++;
         $display("FAIL stall_hold: got cycle %0d unstable %0d data %h tag %h expected 34/0/%h/3c",
                  rc, un, d, 32'h12345 * 32'h777, t);
      end
      nCompared++;
      if (vc !== 1 || st !== 0 || edn !== 1 || ic !== 45) begin
         nMismatched++;
         $display("FAIL stall_grant: got valid %0d stray %0d ex_done %0d idle %0d expected 1/0/1/45",
                  vc, st, edn, ic);
      end
      @(posedge clk); #1;
      issue_valid = 1'b0;
      nCompared++;
      if (ex_done !== 1'b1 || busy !== 1'b1) begin
         nMismatched++;
         $display("FAIL stall_recapture: got ex_done %b busy %b expected 1/1", ex_done, busy);
      end
      cdb_grant = 1'b1; seen2 = 1'b0; drained = 1'b0; got2 = 32'h0;
      for (int c = 0; c < 100; c++) begin
         if (cdb_valid && !seen2) begin seen2 = 1'b1; got2 = cdb_data; end
         if (!busy) begin drained = 1'b1; break; end
         @(posedge clk); #1;
      end
      cdb_grant = 1'b0;
      nCompared++;
      if (!drained || !seen2 || got2 !== 32'h12345 * 32'h777) begin
         nMismatched++;
         $display("FAIL stall_second_op: got drained %0d seen %0d data %h expected 1/1/%h",
                  drained, seen2, got2, 32'h12345 * 32'h777);
      end
   endtask

   task automatic test_invalid_token();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      applyStimulus(3'b000, 32'd11, 32'd13, 6'h01, 1'b0, -1, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (edn !== 1 || edc !== 1 || rc !== -1 || vc !== 0 || st !== 0) begin
         nMismatched++;
         $display("FAIL bubble_no_req: got ex_done %0d@%0d req %0d valid %0d stray %0d expected 1@1/-1/0/0",
                  edn, edc, rc, vc, st);
      end
      nCompared++;
      if (ic !== 34) begin
         nMismatched++;
         $display("FAIL bubble_idle: got cycle %0d expected 34", ic);
      end
      applyStimulus(3'b100, 32'd11, 32'd13, 6'h22, 1'b1, 0, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (d !== 32'h0 || rc !== 34 || t !== 6'h22) begin
         nMismatched++;
         $display("FAIL non_mul_zero: got data %h cycle %0d tag %h expected 0/34/22", d, rc, t);
      end
   endtask

   task automatic test_early_out();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      applyStimulus(3'b000, 32'h0, 32'h1234, 6'h11, 1'b1, 0, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (rc !== (EARLY_OUT ? 2 : 34) || d !== 32'h0 || edc !== 1) begin
         nMismatched++;
         $display("FAIL zero_operand_a: got cycle %0d data %h ex_done@%0d expected %0d/0/1",
                  rc, d, edc, EARLY_OUT ? 2 : 34);
      end
      applyStimulus(3'b001, 32'hFFFFFFFB, 32'h0, 6'h12, 1'b1, 0, 1'b0,
                    edc, edn, rc, d, t, vc, st, ic, un, to);
      nCompared++;
      if (rc !== (EARLY_OUT ? 2 : 34) || d !== 32'h0 || ic !== rc + 1) begin
         nMismatched++;
         $display("FAIL zero_operand_b: got cycle %0d data %h idle %0d expected %0d/0/%0d",
                  rc, d, ic, EARLY_OUT ? 2 : 34, (EARLY_OUT ? 2 : 34) + 1);
      end
   endtask

   task automatic test_random();
      int edc, edn, rc, vc, st, ic; logic [31:0] d; logic [TAG_W-1:0] t; bit un, to;
      logic [2:0] f3; logic [31:0] a, b; logic [TAG_W-1:0] tg; logic tv; int gd, lat, expIdle;
      for (int n = 0; n < 24; n++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: a = 32'h0;
            1: a = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFFFFFF;
            2: b = 32'h80000000;
            default: b = $urandom;
         endcase
         tg  = 6'($urandom_range(0, 63));
         tv  = ($urandom_range(0, 4) != 0);
         gd  = int'($urandom_range(0, 3));
         lat = expLatency(a, b);
         expIdle = tv ? lat + gd + 1 : lat;
         applyStimulus(f3, a, b, tg, tv, gd, 1'b0, edc, edn, rc, d, t, vc, st, ic, un, to);
         nCompared++;
         if (tv && (d !== refResult(f3, a, b) || t !== tg || rc !== lat)) begin
            nMismatched++;
            $display("FAIL rand_%0d_result: f3 %b a %h b %h got %h tag %h cycle %0d expected %h/%h/%0d",
                     n, f3, a, b, d, t, rc, refResult(f3, a, b), tg, lat);
         end else if (!tv && (rc !== -1 || vc !== 0)) begin
            nMismatched++;
            $display("FAIL rand_%0d_bubble: got req %0d valid %0d expected -1/0", n, rc, vc);
         end
         nCompared++;
         if (edc !== 1 || edn !== 1 || ic !== expIdle || un || st !== 0) begin
            nMismatched++;
            $display("FAIL rand_%0d_timing: got ex_done %0d@%0d idle %0d unstable %0d stray %0d expected 1@1/%0d/0/0",
                     n, edn, edc, ic, un, st, expIdle);
         end
      end
   endtask

   initial begin
      nCompared = 0; nMismatched = 0;
      issue_valid = 1'b0; rs1_data = 32'h0; rs2_data = 32'h0; rd_token = '0;
      funct3 = 3'b000; cdb_grant = 1'b0; rst = 1'b1;
      $display("[TB] start, early-out %0d", EARLY_OUT);
      test_reset();
      test_basic_mul();
      test_high_words();
      test_reset_mid_op();
      test_grant_stall();
      test_invalid_token();
      test_early_out();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
